// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: walks DIGITS packed BCD digits MSD-first,
// one per clock, through a single acc*10+digit accumulator; flags digits above 9.
module bcd_to_binary_seq #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      binary_out,
   output logic                  err
);

   localparam int SR_W  = 4 * DIGITS;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t            state_reg, state_next;
   logic [SR_W-1:0]   shift_reg, shift_next;
   logic [BIN_W-1:0]  acc_reg, acc_next;
   logic [BIN_W-1:0]  bin_reg, bin_next;
   logic              err_reg, err_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;

   logic [3:0]        digit;
   logic [BIN_W-1:0]  mac;

   // The digit under conversion is always the top nibble; the register shifts left.
   assign digit = shift_reg[SR_W-1 -: 4];
   assign mac   = acc_reg * BIN_W'(10) + BIN_W'(digit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         acc_reg   <= '0;
         bin_reg   <= '0;
         err_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         acc_reg   <= acc_next;
         bin_reg   <= bin_next;
         err_reg   <= err_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      acc_next   = acc_reg;
      bin_next   = bin_reg;
      err_next   = err_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               shift_next = bcd_in;
               acc_next   = '0;
               cnt_next   = '0;
               state_next = CONV;
            end
         end
         CONV: begin
            if (digit > 4'd9) begin
               // Abort on the first bad digit; remaining digits are never examined.
               err_next   = 1'b1;
               bin_next   = '0;
               state_next = DONE;
            end else begin
               acc_next   = mac;
               shift_next = shift_reg << 4;
               cnt_next   = cnt_reg + CNT_W'(1);
               if (cnt_reg == CNT_W'(DIGITS - 1)) begin
                  bin_next   = mac;
                  err_next   = 1'b0;
                  state_next = DONE;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign ready      = (state_reg == IDLE);
   assign busy       = ~ready;
   assign done       = (state_reg == DONE);
   assign binary_out = bin_reg;
   assign err        = err_reg;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: a 4-digit and a 2-digit instance,
// table vectors, hand-written handshake/reset sequences and randomized words.
module tb_bcd_to_binary_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        a_start = 1'b0;
   logic [15:0] a_bcd = '0;
   logic        a_ready, a_busy, a_done, a_err;
   logic [13:0] a_bin;

   logic        b_start = 1'b0;
   logic [7:0]  b_bcd = '0;
   logic        b_ready, b_busy, b_done, b_err;
   logic [6:0]  b_bin;

   int total = 0;
   int bad   = 0;
   bit use_b = 1'b0;

   always #5 clk = ~clk;

   bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .bcd_in(a_bcd),
      .ready(a_ready), .busy(a_busy), .done(a_done), .binary_out(a_bin), .err(a_err)
   );

   bcd_to_binary_seq #(.DIGITS(2), .BIN_W(7)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .bcd_in(b_bcd),
      .ready(b_ready), .busy(b_busy), .done(b_done), .binary_out(b_bin), .err(b_err)
   );

   wire        m_ready = use_b ? b_ready : a_ready;
   wire        m_busy  = use_b ? b_busy  : a_busy;
   wire        m_done  = use_b ? b_done  : a_done;
   wire        m_err   = use_b ? b_err   : a_err;
   wire [13:0] m_bin   = use_b ? {7'd0, b_bin} : a_bin;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: decimal value of the digits MSD-first; a bad digit at position k
   // ends the walk after k good digits plus the aborting edge.
   function automatic void model(input int nd, input logic [15:0] bcd,
                                 output int val, output bit e, output int lat);
      int d;
      val = 0; e = 1'b0; lat = nd + 1;
      for (int k = 0; k < nd; k++) begin
         d = int'((bcd >> (4 * (nd - 1 - k))) & 16'hF);
         if (d > 9) begin
            val = 0; e = 1'b1; lat = k + 2;
            return;
         end
         val = val * 10 + d;
      end
   endfunction

   task automatic run(input bit ub, input logic [15:0] bcd, input int exp_val,
                      input bit exp_err, input int exp_lat, input string name);
      int lat;
      use_b = ub;
      @(negedge clk);
      if (ub) begin b_bcd = bcd[7:0]; b_start = 1'b1; end
      else    begin a_bcd = bcd;      a_start = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      a_start = 1'b0; b_start = 1'b0;
      chk({name, " ready_fall"}, int'(m_ready), 0);
      lat = 1;
      while (!m_done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " value"}, int'(m_bin), exp_val);
      chk({name, " err"}, int'(m_err), int'(exp_err));
      chk({name, " busy_at_done"}, int'(m_busy), 1);
      @(negedge clk);
      chk({name, " ready_back"}, int'(m_ready), 1);
      chk({name, " done_pulse"}, int'(m_done), 0);
      $display("xact %s dut=%s bcd=%h bin=%0d err=%0d lat=%0d", name, ub ? "B" : "A",
               bcd, m_bin, m_err, lat);
   endtask

   typedef struct {
      bit          ub;
      logic [15:0] bcd;
      int          exp_val;
      bit          exp_err;
      int          exp_lat;
      string       name;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int lat, val, cyc;
      bit e, saw_done;
      logic [15:0] w;

      tbl[0] = '{1'b0, 16'h1234, 1234, 1'b0, 5, "v1234"};
      tbl[1] = '{1'b0, 16'h0000, 0,    1'b0, 5, "v0000"};
      tbl[2] = '{1'b0, 16'h9999, 9999, 1'b0, 5, "v9999"};
      tbl[3] = '{1'b0, 16'h12A4, 0,    1'b1, 4, "v12A4"};
      tbl[4] = '{1'b0, 16'h0042, 42,   1'b0, 5, "v0042"};
      tbl[5] = '{1'b0, 16'hF000, 0,    1'b1, 2, "vF000"};
      tbl[6] = '{1'b0, 16'h000A, 0,    1'b1, 5, "v000A"};
      tbl[7] = '{1'b1, 16'h0099, 99,   1'b0, 3, "b99"};
      tbl[8] = '{1'b1, 16'h009F, 0,    1'b1, 3, "b9F"};

      // Reset state
      #1;
      chk("rst ready", int'(a_ready), 1);
      chk("rst busy", int'(a_busy), 0);
      chk("rst done", int'(a_done), 0);
      chk("rst bin", int'(a_bin), 0);
      chk("rst err", int'(a_err), 0);
      chk("rst b ready", int'(b_ready), 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++)
         run(tbl[i].ub, tbl[i].bcd, tbl[i].exp_val, tbl[i].exp_err, tbl[i].exp_lat, tbl[i].name);

      // Start held high; bcd_in changes mid-CONV; a stray pulse in CONV is dropped
      use_b = 1'b0;
      @(negedge clk);
      a_bcd = 16'h0007; a_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_bcd = 16'h0555;
      lat = 1;
      while (!a_done && lat < 20) begin @(negedge clk); lat++; end
      chk("held first latency", lat, 5);
      chk("held first value", int'(a_bin), 7);
      @(negedge clk);
      chk("held idle cycle", int'(a_ready), 1);
      @(negedge clk);
      chk("held reaccept", int'(a_ready), 0);
      a_start = 1'b0;
      @(negedge clk);
      chk("held bin stable", int'(a_bin), 7);
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      lat = 3;
      while (!a_done && lat < 20) begin @(negedge clk); lat++; end
      chk("held second latency", lat, 5);
      chk("held second value", int'(a_bin), 555);
      saw_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (a_done || !a_ready) saw_done = 1'b1;
      end
      chk("no queued start", int'(saw_done), 0);
      $display("xact held-start bcd=0007/0555 bin=%0d", a_bin);

      // Reset during CONV
      @(negedge clk);
      a_bcd = 16'h8765; a_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst ready", int'(a_ready), 1);
      chk("midrst busy", int'(a_busy), 0);
      chk("midrst done", int'(a_done), 0);
      chk("midrst bin", int'(a_bin), 0);
      chk("midrst err", int'(a_err), 0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (a_done) saw_done = 1'b1;
      end
      chk("midrst no done", int'(saw_done), 0);
      $display("xact midrst bcd=8765 bin=%0d", a_bin);
      run(1'b0, 16'h0010, 10, 1'b0, 5, "post_rst");

      // Randomized words against the reference model
      for (int i = 0; i < 40; i++) begin
         w = '0;
         for (int k = 0; k < 4; k++)
            w[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                     : 4'($urandom_range(0, 9));
         model(4, w, val, e, cyc);
         run(1'b0, w, val, e, cyc, "rndA");
      end
      for (int i = 0; i < 12; i++) begin
         w = 16'($urandom_range(0, 255));
         model(2, w, val, e, cyc);
         run(1'b1, w, val, e, cyc, "rndB");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
